pc_prefetch_queue: RTL and testbench

Parametrised program-counter and instruction-prefetch unit for the GPU/DSP cores. It replaces the fixed 23-bit PC with implicit queue back-off by an explicit prefetch FIFO. The FIFO has configurable depth and fetch width, and handles misaligned jump targets. The unit sits between the core's instruction decoder and the local-RAM/bus fetch port. It provides absolute, relative and host-write PC loads, and reports the architecturally visible program count.

---
 rtl/pc_prefetch_queue_pkg.sv | 35 +++
 rtl/pc_prefetch_queue_fifo.sv | 75 +++++++
 rtl/pc_prefetch_queue.sv | 145 ++++++++++++++
 tb/tb_pc_prefetch_queue.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_prefetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_prefetch_queue_pkg
//  Description : Shared constants, load-source encoding and configuration
//                checks for the program-counter / instruction-prefetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_prefetch_queue_pkg;

    // Word address loaded at reset (byte address 0xFF0008).
    localparam logic [22:0] c_RESET_PC_DEFAULT = 23'h7F8004;

    // Instructions are 16-bit words: byte address = word address << 1.
    localparam int c_BYTE_SHIFT = 1;

    // Which source (if any) reloads the PC this cycle, highest priority first.
    typedef enum logic [1:0] {
        LD_NONE = 2'd0,
        LD_JABS = 2'd1,
        LD_JREL = 2'd2,
        LD_HOST = 2'd3
    } load_src_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Fetch width and queue depth must both be powers of two, and the queue
    // must be able to hold at least one complete fetch.
    function automatic bit cfg_legal(input int fw, input int qdepth);
        return is_pow2(fw) && is_pow2(qdepth) && (qdepth >= fw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_prefetch_queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : prefetch_fifo
//  Description : Circular instruction buffer. Accepts 0..FW words per cycle,
//                pops at most one, and flushes synchronously.
//  Revision    : 1.0 - initial release
// ============================================================================
module prefetch_fifo #(
    parameter int DW     = 16,
    parameter int QDEPTH = 4,
    parameter int FW     = 2,
    parameter int CW     = $clog2(QDEPTH + 1),
    parameter int PCW    = $clog2(FW + 1)
) (
    input  logic               sys_clk,
    input  logic               resetl,
    input  logic               ce,
    input  logic               flush,
    input  logic [PCW-1:0]     push_cnt,
    input  logic [FW*DW-1:0]   push_data,
    input  logic               pop,
    output logic [DW-1:0]      head,
    output logic [CW-1:0]      count
);

    // Pointer width; a one-entry queue still needs a 1-bit pointer.
    localparam int            c_PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [c_PW-1:0] c_PMASK = c_PW'(QDEPTH - 1);

    logic [DW-1:0]   r_mem [QDEPTH];
    logic [c_PW-1:0] r_rd;
    logic [c_PW-1:0] r_wr;
    logic [CW-1:0]   r_count;
    logic            w_pop_ok;

    // Never pop an empty queue, even if the caller asks.
    assign w_pop_ok = pop && (r_count != '0);

    // Pointer and occupancy update; flush wins over push/pop.
    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (ce) begin
            if (flush) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
            end else begin
                r_wr    <= (r_wr + c_PW'(push_cnt)) & c_PMASK;
                if (w_pop_ok) begin
                    r_rd <= (r_rd + c_PW'(1)) & c_PMASK;
                end
                r_count <= r_count + CW'(push_cnt) - CW'(w_pop_ok);
            end
        end
    end

    // Storage write: word i of push_data lands at wr+i for i < push_cnt.
    always_ff @(posedge sys_clk) begin
        if (resetl && ce && !flush) begin
            for (int i = 0; i < FW; i++) begin
                if (PCW'(i) < push_cnt) begin
                    r_mem[(r_wr + c_PW'(i)) & c_PMASK] <= push_data[i*DW +: DW];
                end
            end
        end
    end

    assign head  = r_mem[r_rd];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pc_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : pc_prefetch_queue
//  Description : Program counter and instruction prefetch queue. Fetches
//                FW-word aligned blocks ahead of the decoder, discards the
//                leading words of a misaligned jump target, and supports
//                absolute, relative and host PC loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_prefetch_queue
    import pc_prefetch_queue_pkg::*;
#(
    parameter int            AW       = 23,
    parameter int            DW       = 16,
    parameter int            FW       = 2,
    parameter int            QDEPTH   = 4,
    parameter logic [AW-1:0] RESET_PC = AW'(c_RESET_PC_DEFAULT)
) (
    input  logic              sys_clk,
    input  logic              resetl,
    input  logic              ce,
    input  logic              go,
    input  logic              pcwr,
    input  logic [AW:0]       host_din,
    input  logic              jabs,
    input  logic              jrel,
    input  logic [AW:0]       jabs_addr,
    input  logic [AW-1:0]     jrel_off,
    output logic              fetch_req,
    output logic [AW-1:0]     fetch_addr,
    input  logic              fetch_ack,
    input  logic [FW*DW-1:0]  fetch_data,
    output logic              instr_valid,
    output logic [DW-1:0]     instr,
    input  logic              instr_take,
    output logic [AW:0]       program_count
);

    localparam int            c_SW         = (FW > 1) ? $clog2(FW) : 1;
    localparam int            c_CW         = $clog2(QDEPTH + 1);
    localparam int            c_PCW        = $clog2(FW + 1);
    localparam logic [AW-1:0] c_ALIGN_MASK = ~AW'(FW - 1);
    localparam logic [c_SW-1:0] c_RESET_SKIP = c_SW'(RESET_PC & ~c_ALIGN_MASK);

    // Reject illegal FW/QDEPTH combinations at elaboration.
    if (!cfg_legal(FW, QDEPTH)) begin : g_cfg_illegal
        $error("pc_prefetch_queue: FW and QDEPTH must be powers of two with QDEPTH >= FW");
    end

    logic [AW-1:0]    r_head_pc;
    logic [AW-1:0]    r_fetch_pc;
    logic [c_SW-1:0]  r_skip;

    load_src_t        w_load_src;
    logic [AW-1:0]    w_target;
    logic [c_SW-1:0]  w_target_skip;
    logic             w_load;
    logic             w_space_ok;
    logic             w_accept;
    logic             w_pop;
    logic [c_CW-1:0]  w_count;
    logic [DW-1:0]    w_head;
    logic [c_PCW-1:0] w_push_cnt;
    logic [FW*DW-1:0] w_push_data;
    logic             w_unused_bits;

    // Byte-address bit 0 of the absolute and host addresses carries no meaning.
    assign w_unused_bits = &{1'b0, host_din[0], jabs_addr[0]};

    // Load source priority: absolute jump, relative jump, host write (stopped only).
    always_comb begin
        w_load_src = LD_NONE;
        w_target   = r_head_pc;
        if (jabs) begin
            w_load_src = LD_JABS;
            w_target   = jabs_addr[AW:c_BYTE_SHIFT];
        end else if (jrel) begin
            w_load_src = LD_JREL;
            w_target   = r_head_pc + jrel_off;
        end else if (pcwr && !go) begin
            w_load_src = LD_HOST;
            w_target   = host_din[AW:c_BYTE_SHIFT];
        end
    end

    assign w_load        = ce && (w_load_src != LD_NONE);
    assign w_target_skip = c_SW'(w_target & ~c_ALIGN_MASK);

    // Request only when a whole fetch block is guaranteed to fit.
    assign w_space_ok  = (c_CW'(QDEPTH) - w_count) >= c_CW'(FW);
    assign fetch_req   = go && resetl && w_space_ok && !w_load;
    assign fetch_addr  = r_fetch_pc;

    assign w_accept    = ce && fetch_ack && fetch_req;
    assign instr_valid = go && (w_count != '0);
    assign instr       = w_head;
    assign w_pop       = ce && instr_valid && instr_take && !w_load;

    // Drop the leading 'skip' words of a misaligned block before pushing.
    assign w_push_cnt  = w_accept ? (c_PCW'(FW) - c_PCW'(r_skip)) : '0;
    assign w_push_data = fetch_data >> (int'(r_skip) * DW);

    assign program_count = {r_head_pc, 1'b0};

    // PC, fetch pointer and skip count: loads override fetch/take progress.
    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            r_head_pc  <= RESET_PC;
            r_fetch_pc <= RESET_PC & c_ALIGN_MASK;
            r_skip     <= c_RESET_SKIP;
        end else if (w_load) begin
            r_head_pc  <= w_target;
            r_fetch_pc <= w_target & c_ALIGN_MASK;
            r_skip     <= w_target_skip;
        end else if (ce) begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + AW'(FW);
                r_skip     <= '0;
            end
            if (w_pop) begin
                r_head_pc <= r_head_pc + AW'(1);
            end
        end
    end

    prefetch_fifo #(
        .DW     (DW),
        .QDEPTH (QDEPTH),
        .FW     (FW),
        .CW     (c_CW),
        .PCW    (c_PCW)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .ce        (ce),
        .flush     (w_load),
        .push_cnt  (w_push_cnt),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_pc_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_prefetch_queue
//  Description : Self-checking bench: vector table, directed corner cases and
//                randomized traffic against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_prefetch_queue;

    localparam int          AW     = 23;
    localparam int          DW     = 16;
    localparam int          FW     = 2;
    localparam int          QDEPTH = 4;
    localparam logic [22:0] RST_PC = 23'h7F8004;

    logic              sys_clk = 1'b0;
    logic              resetl = 1'b0;
    logic              ce = 1'b1;
    logic              go = 1'b0;
    logic              pcwr = 1'b0;
    logic [AW:0]       host_din = '0;
    logic              jabs = 1'b0;
    logic              jrel = 1'b0;
    logic [AW:0]       jabs_addr = '0;
    logic [AW-1:0]     jrel_off = '0;
    logic              fetch_req;
    logic [AW-1:0]     fetch_addr;
    logic              fetch_ack = 1'b0;
    logic [FW*DW-1:0]  fetch_data = '0;
    logic              instr_valid;
    logic [DW-1:0]     instr;
    logic              instr_take = 1'b0;
    logic [AW:0]       program_count;

    int checks = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    pc_prefetch_queue #(
        .AW(AW), .DW(DW), .FW(FW), .QDEPTH(QDEPTH), .RESET_PC(RST_PC)
    ) dut (
        .sys_clk(sys_clk), .resetl(resetl), .ce(ce), .go(go), .pcwr(pcwr),
        .host_din(host_din), .jabs(jabs), .jrel(jrel), .jabs_addr(jabs_addr),
        .jrel_off(jrel_off), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data), .instr_valid(instr_valid),
        .instr(instr), .instr_take(instr_take), .program_count(program_count)
    );

    // Memory contents: a distinct word per address.
    function automatic logic [15:0] memw(input logic [22:0] a);
        return a[15:0] ^ {a[22:16], 9'h0A5};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: head word address, plain queue of words, next fetch address.
    logic [22:0] m_head;
    logic [22:0] m_fa;
    int          m_skip;
    logic [15:0] m_q[$];
    logic        m_load;
    logic        e_req;
    logic        e_valid;

    task automatic model_reset();
        m_head = RST_PC;
        m_fa   = RST_PC & ~23'(FW - 1);
        m_skip = int'(RST_PC % FW);
        m_q.delete();
    endtask

    // Settle inputs, serve the fetch port from memory, compare to the model.
    task automatic settle();
        #1;
        for (int i = 0; i < FW; i++) fetch_data[i*DW +: DW] = memw(fetch_addr + 23'(i));
        #1;
        m_load  = resetl && ce && (jabs || jrel || (pcwr && !go));
        e_req   = go && resetl && ((QDEPTH - m_q.size()) >= FW) && !m_load;
        e_valid = go && (m_q.size() > 0);
        chk("fetch_req", {31'd0, fetch_req}, {31'd0, e_req});
        chk("fetch_addr", {9'd0, fetch_addr}, {9'd0, m_fa});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
        if (e_valid) chk("instr", {16'd0, instr}, {16'd0, m_q[0]});
        chk("program_count", {8'd0, program_count}, {8'd0, m_head, 1'b0});
    endtask

    // Clock edge: advance the model by the architectural rules.
    task automatic advance();
        logic [22:0] t;
        @(posedge sys_clk);
        if (!resetl) begin
            model_reset();
        end else if (ce) begin
            if (m_load) begin
                if (jabs)      t = jabs_addr[23:1];
                else if (jrel) t = m_head + jrel_off;
                else           t = host_din[23:1];
                m_head = t;
                m_q.delete();
                m_fa   = t & ~23'(FW - 1);
                m_skip = int'(t % FW);
            end else begin
                if (e_valid && instr_take) begin
                    void'(m_q.pop_front());
                    m_head = m_head + 23'd1;
                end
                if (e_req && fetch_ack) begin
                    for (int i = m_skip; i < FW; i++) m_q.push_back(memw(m_fa + 23'(i)));
                    m_fa   = m_fa + 23'(FW);
                    m_skip = 0;
                end
            end
        end
        @(negedge sys_clk);
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic idle(input logic g);
        resetl = 1'b1; ce = 1'b1; go = g; pcwr = 1'b0; jabs = 1'b0; jrel = 1'b0;
        fetch_ack = 1'b0; instr_take = 1'b0;
    endtask

    task automatic jump_abs(input logic [23:0] byte_addr);
        idle(1'b1);
        jabs = 1'b1; jabs_addr = byte_addr;
        cyc();
        jabs = 1'b0;
    endtask

    typedef struct {
        logic        rst_n;
        logic        go;
        logic        pcwr;
        logic [23:0] host;
        logic        ack;
        logic        e_req;
        logic [22:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [23:0] e_pc;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(input logic r, input logic g, input logic pw, input logic [23:0] h,
                                input logic a, input logic er, input logic [22:0] ea,
                                input logic ev, input logic [15:0] ei, input logic [23:0] ep);
        vec_t v;
        v.rst_n = r; v.go = g; v.pcwr = pw; v.host = h; v.ack = a;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
        return v;
    endfunction

    initial begin
        logic [22:0] e;

        // Reset-state, fill-to-full and host-write vectors.
        tbl[0] = mk(0, 0, 0, 24'h0,      0, 0, 23'h7F8004, 0, 16'h0,            24'hFF0008);
        tbl[1] = mk(1, 1, 0, 24'h0,      1, 1, 23'h7F8004, 0, 16'h0,            24'hFF0008);
        tbl[2] = mk(1, 1, 0, 24'h0,      1, 1, 23'h7F8006, 1, memw(23'h7F8004), 24'hFF0008);
        tbl[3] = mk(1, 1, 0, 24'h0,      1, 0, 23'h7F8008, 1, memw(23'h7F8004), 24'hFF0008);
        tbl[4] = mk(1, 0, 0, 24'h0,      0, 0, 23'h7F8008, 0, 16'h0,            24'hFF0008);
        tbl[5] = mk(1, 0, 1, 24'hF03000, 0, 0, 23'h7F8008, 0, 16'h0,            24'hFF0008);
        tbl[6] = mk(1, 0, 0, 24'h0,      0, 0, 23'h781800, 0, 16'h0,            24'hF03000);
        tbl[7] = mk(1, 1, 1, 24'h000010, 0, 1, 23'h781800, 0, 16'h0,            24'hF03000);
        tbl[8] = mk(1, 1, 0, 24'h0,      1, 1, 23'h781800, 0, 16'h0,            24'hF03000);
        tbl[9] = mk(1, 1, 0, 24'h0,      0, 1, 23'h781802, 1, memw(23'h781800), 24'hF03000);

        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        model_reset();

        for (int n = 0; n < 10; n++) begin
            idle(tbl[n].go);
            resetl = tbl[n].rst_n; pcwr = tbl[n].pcwr; host_din = tbl[n].host;
            fetch_ack = tbl[n].ack;
            settle();
            chk($sformatf("tbl%0d_req", n), {31'd0, fetch_req}, {31'd0, tbl[n].e_req});
            chk($sformatf("tbl%0d_addr", n), {9'd0, fetch_addr}, {9'd0, tbl[n].e_addr});
            chk($sformatf("tbl%0d_valid", n), {31'd0, instr_valid}, {31'd0, tbl[n].e_valid});
            if (tbl[n].e_valid) chk($sformatf("tbl%0d_instr", n), {16'd0, instr}, {16'd0, tbl[n].e_instr});
            chk($sformatf("tbl%0d_pc", n), {8'd0, program_count}, {8'd0, tbl[n].e_pc});
            advance();
        end

        // Streaming: ack and take every cycle.
        jump_abs(24'hFF0008);
        fetch_ack = 1'b1; instr_take = 1'b1;
        e = 23'h7F8004;
        for (int n = 0; n < 20; n++) begin
            settle();
            if (instr_valid) begin
                chk("t2_instr", {16'd0, instr}, {16'd0, memw(e)});
                chk("t2_pc", {8'd0, program_count}, {8'd0, e, 1'b0});
                e = e + 23'd1;
            end
            advance();
        end
        chk("t2_progress", {31'd0, (e - 23'h7F8004) >= 23'd15}, 32'd1);

        // Relative jump, even target.
        jump_abs(24'hFF0008);
        fetch_ack = 1'b1; cyc(); fetch_ack = 1'b0;
        instr_take = 1'b1; cyc(); instr_take = 1'b0;
        jrel = 1'b1; jrel_off = 23'd3;
        settle(); chk("t3_req_on_load", {31'd0, fetch_req}, 32'd0); advance();
        jrel = 1'b0;
        settle();
        chk("t3_addr", {9'd0, fetch_addr}, {9'd0, 23'h7F8008});
        chk("t3_pc", {8'd0, program_count}, 32'h00FF0010);
        chk("t3_req_next", {31'd0, fetch_req}, 32'd1);
        advance();

        // Relative jump, odd target: leading word dropped.
        jump_abs(24'hFF0008);
        fetch_ack = 1'b1; cyc(); fetch_ack = 1'b0;
        instr_take = 1'b1; cyc(); instr_take = 1'b0;
        jrel = 1'b1; jrel_off = 23'd4; cyc(); jrel = 1'b0;
        settle();
        chk("t3o_addr", {9'd0, fetch_addr}, {9'd0, 23'h7F8008});
        chk("t3o_pc", {8'd0, program_count}, 32'h00FF0012);
        fetch_ack = 1'b1; advance(); fetch_ack = 1'b0;
        settle();
        chk("t3o_valid", {31'd0, instr_valid}, 32'd1);
        chk("t3o_instr", {16'd0, instr}, {16'd0, memw(23'h7F8009)});
        advance();

        // Absolute jump colliding with ack and take.
        jump_abs(24'hFF0008);
        fetch_ack = 1'b1; cyc();
        jabs = 1'b1; jabs_addr = 24'h001000; instr_take = 1'b1;
        cyc();
        idle(1'b1);
        settle();
        chk("t4_valid", {31'd0, instr_valid}, 32'd0);
        chk("t4_addr", {9'd0, fetch_addr}, {9'd0, 23'h000800});
        chk("t4_pc", {8'd0, program_count}, 32'h00001000);
        chk("t4_req", {31'd0, fetch_req}, 32'd1);
        advance();

        // Wrap across the top of memory, then reset mid-fetch.
        jump_abs(24'hFFFFFC);
        settle(); chk("t6_addr0", {9'd0, fetch_addr}, {9'd0, 23'h7FFFFE});
        fetch_ack = 1'b1; advance();
        settle(); chk("t6_addr1", {9'd0, fetch_addr}, 32'd0); advance();
        fetch_ack = 1'b0; instr_take = 1'b1;
        settle(); chk("t6_pc0", {8'd0, program_count}, 32'h00FFFFFC); advance();
        settle(); chk("t6_pc1", {8'd0, program_count}, 32'h00FFFFFE); advance();
        settle(); chk("t6_pc2", {8'd0, program_count}, 32'd0); advance();
        instr_take = 1'b0;
        settle(); chk("t6_req_before", {31'd0, fetch_req}, 32'd1); advance();
        resetl = 1'b0; fetch_ack = 1'b1;
        cyc();
        settle();
        chk("t6_req_after_rst", {31'd0, fetch_req}, 32'd0);
        chk("t6_valid_after_rst", {31'd0, instr_valid}, 32'd0);
        chk("t6_pc_after_rst", {8'd0, program_count}, 32'h00FF0008);
        advance();
        idle(1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            resetl     = ($urandom_range(0, 199) != 0);
            ce         = ($urandom_range(0, 9) != 0);
            go         = ($urandom_range(0, 9) != 0);
            jabs       = ($urandom_range(0, 39) == 0);
            jrel       = ($urandom_range(0, 39) == 0);
            pcwr       = ($urandom_range(0, 14) == 0);
            jabs_addr  = 24'($urandom);
            host_din   = 24'($urandom);
            jrel_off   = ($urandom_range(0, 1) == 1) ? (23'($urandom_range(0, 8)) - 23'd4) : 23'($urandom);
            fetch_ack  = ($urandom_range(0, 1) == 1);
            instr_take = ($urandom_range(0, 9) < 6);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
